// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl
// Parses SOF / LEN / payload / CSUM frames coming out of uart_rx into a local
// buffer and replays the payload on a ready/valid byte stream once the XOR
// checksum matches. Broken frames are dropped and reported with an error code.
// Optional build macro RX_FRAME_TIMEOUT_EN adds an inter-byte gap timeout
// (error code 4) while a frame is being received.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// S_IDLE    | hunting for SOF_BYTE, everything else dropped
// S_LEN     | SOF seen, next byte is the payload length
// S_PAYLOAD | storing payload bytes, folding them into the checksum
// S_CSUM    | next byte is compared with the running checksum
// S_DRAIN   | frame verified, payload offered on m_valid/m_data/m_last
module uart_rx_frame_ctrl #(
   parameter int unsigned MAX_LEN        = 16,
   parameter logic [7:0]  SOF_BYTE       = 8'h7E,
   parameter int unsigned TIMEOUT_CYCLES = 60000
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       enable,
   output logic       uart_rx_en,
   input  logic       rx_valid,
   input  logic [7:0] rx_data,
   input  logic       rx_break,
   output logic       m_valid,
   output logic [7:0] m_data,
   output logic       m_last,
   input  logic       m_ready,
   output logic       frame_ok,
   output logic       frame_err,
   output logic [2:0] err_code
);

   localparam int unsigned   PW        = $clog2(MAX_LEN + 1);
   localparam int unsigned   AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam logic [PW-1:0] PTR_ONE   = PW'(1);
   localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);

   localparam logic [2:0] ERR_LEN = 3'd1;
   localparam logic [2:0] ERR_CSM = 3'd2;
   localparam logic [2:0] ERR_BRK = 3'd3;
   localparam logic [2:0] ERR_TMO = 3'd4;
   localparam logic [2:0] ERR_OVR = 3'd5;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN,
      S_PAYLOAD,
      S_CSUM,
      S_DRAIN
   } state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] len_q, len_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [7:0]    csum_q, csum_d;
   logic          frame_ok_q, frame_ok_d;
   logic          frame_err_q, frame_err_d;
   logic [2:0]    err_code_q, err_code_d;
   logic          rx_en_q;
   logic          buf_we;
   logic          gap_tc;
   logic [7:0]    pbuf_q [MAX_LEN];

`ifdef RX_FRAME_TIMEOUT_EN
   localparam int unsigned   GW       = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [GW-1:0] GAP_LOAD = GW'(TIMEOUT_CYCLES - 1);

   logic [GW-1:0] gap_q, gap_d;
   logic          mid_frame;

   assign mid_frame = (state_q == S_LEN) || (state_q == S_PAYLOAD) || (state_q == S_CSUM);
   assign gap_tc    = (gap_q == '0);

   // gap timer reloads on every byte and outside the frame body, else counts down
   always_comb begin
      gap_d = GAP_LOAD;
      if (mid_frame && !rx_valid && !gap_tc) gap_d = gap_q - GW'(1);
   end

   // gap timer register
   always_ff @(posedge clk) begin
      if (!resetn) gap_q <= '0;
      else         gap_q <= gap_d;
   end
`else
   assign gap_tc = 1'b0;
`endif

   // next-state and per-frame bookkeeping
   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      csum_d      = csum_q;
      frame_ok_d  = 1'b0;
      frame_err_d = 1'b0;
      err_code_d  = err_code_q;
      buf_we      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (rx_valid && !rx_break && enable && rx_data == SOF_BYTE) state_d = S_LEN;
         end
         S_LEN, S_PAYLOAD, S_CSUM: begin
            // break outranks both enable falling and the 0x00 data byte
            if (rx_valid && rx_break) begin
               state_d     = S_IDLE;
               frame_err_d = 1'b1;
               err_code_d  = ERR_BRK;
            end else if (!enable) begin
               state_d = S_IDLE;
            end else if (rx_valid) begin
               if (state_q == S_LEN) begin
                  if (rx_data == 8'd0 || rx_data > MAX_LEN_B) begin
                     state_d     = S_IDLE;
                     frame_err_d = 1'b1;
                     err_code_d  = ERR_LEN;
                  end else begin
                     len_d    = rx_data[PW-1:0];
                     csum_d   = rx_data;
                     wr_ptr_d = '0;
                     state_d  = S_PAYLOAD;
                  end
               end else if (state_q == S_PAYLOAD) begin
                  buf_we   = 1'b1;
                  csum_d   = csum_q ^ rx_data;
                  wr_ptr_d = wr_ptr_q + PTR_ONE;
                  if (wr_ptr_q == len_q - PTR_ONE) state_d = S_CSUM;
               end else begin
                  if (rx_data == csum_q) begin
                     frame_ok_d = 1'b1;
                     rd_ptr_d   = '0;
                     state_d    = S_DRAIN;
                  end else begin
                     state_d     = S_IDLE;
                     frame_err_d = 1'b1;
                     err_code_d  = ERR_CSM;
                  end
               end
            end else if (gap_tc) begin
               state_d     = S_IDLE;
               frame_err_d = 1'b1;
               err_code_d  = ERR_TMO;
            end
         end
         S_DRAIN: begin
            // incoming bytes cannot be stored while draining; flag and drop
            if (rx_valid) begin
               frame_err_d = 1'b1;
               err_code_d  = ERR_OVR;
            end
            if (m_ready) begin
               rd_ptr_d = rd_ptr_q + PTR_ONE;
               if (rd_ptr_q == len_q - PTR_ONE) state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // state, pointers, checksum and registered status outputs
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q     <= S_IDLE;
         len_q       <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         csum_q      <= '0;
         frame_ok_q  <= 1'b0;
         frame_err_q <= 1'b0;
         err_code_q  <= '0;
         rx_en_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         csum_q      <= csum_d;
         frame_ok_q  <= frame_ok_d;
         frame_err_q <= frame_err_d;
         err_code_q  <= err_code_d;
         rx_en_q     <= enable;
      end
   end

   // payload storage; contents are don't-care until written by the current frame
   always_ff @(posedge clk) begin
      if (buf_we) pbuf_q[wr_ptr_q[AW-1:0]] <= rx_data;
   end

   assign uart_rx_en = rx_en_q;
   assign m_valid    = (state_q == S_DRAIN);
   assign m_data     = m_valid ? pbuf_q[rd_ptr_q[AW-1:0]] : 8'h00;
   assign m_last     = m_valid && (rd_ptr_q == len_q - PTR_ONE);
   assign frame_ok   = frame_ok_q;
   assign frame_err  = frame_err_q;
   assign err_code   = err_code_q;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Testbench for uart_rx_frame_ctrl: directed scenarios plus a randomized frame
// mix checked against a frame-level outcome model.
module tb_uart_rx_frame_ctrl;

   localparam int MAX_LEN = 16;
   localparam int TMO     = 50;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       enable = 1'b0;
   logic       rx_valid = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       rx_break = 1'b0;
   logic       m_ready = 1'b0;
   logic       uart_rx_en, m_valid, m_last, frame_ok, frame_err;
   logic [7:0] m_data;
   logic [2:0] err_code;

   int checks = 0;
   int failures = 0;
   bit rand_ready = 1'b0;

   logic [7:0] mon_data[$];
   bit         mon_last[$];
   int         mon_err[$];
   int         mon_ok = 0;
   int         mon_valid = 0;
   int         mon_ok_novalid = 0;

   always #5 clk = ~clk;

   uart_rx_frame_ctrl #(
      .MAX_LEN(MAX_LEN),
      .SOF_BYTE(8'h7E),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk), .resetn(resetn), .enable(enable), .uart_rx_en(uart_rx_en),
      .rx_valid(rx_valid), .rx_data(rx_data), .rx_break(rx_break),
      .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
      .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code)
   );

   // passive observer on the falling edge
   always @(negedge clk) begin
      if (resetn) begin
         if (m_valid) mon_valid++;
         if (m_valid && m_ready) begin
            mon_data.push_back(m_data);
            mon_last.push_back(m_last);
         end
         if (frame_ok) begin
            mon_ok++;
            if (!m_valid) mon_ok_novalid++;
         end
         if (frame_err) mon_err.push_back(int'(err_code));
      end
   end

   always @(posedge clk) begin
      if (rand_ready) begin
         #1;
         m_ready = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   function automatic logic [7:0] xor_sum(input logic [7:0] len, input logic [7:0] pl[$]);
      logic [7:0] s = len;
      foreach (pl[i]) s ^= pl[i];
      return s;
   endfunction

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] d, input logic brk = 1'b0);
      rx_valid = 1'b1;
      rx_data  = d;
      rx_break = brk;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
      rx_break = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] len, input logic [7:0] pl[$], input logic [7:0] cs);
      send_byte(8'h7E);
      send_byte(len);
      foreach (pl[i]) send_byte(pl[i]);
      send_byte(cs);
   endtask

   task automatic wait_drain(output bit done);
      for (int i = 0; i < 3000; i++) begin
         if (!m_valid) break;
         idle(1);
      end
      done = !m_valid;
   endtask

   task automatic clear_mon();
      mon_data.delete();
      mon_last.delete();
      mon_err.delete();
   endtask

   task automatic test_reset();
      resetn = 1'b0; enable = 1'b1; m_ready = 1'b0;
      idle(3);
      checks++; if (uart_rx_en !== 1'b0) begin failures++; $display("FAIL rst_uart_rx_en got=%b exp=0", uart_rx_en); end
      checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL rst_m_valid got=%b exp=0", m_valid); end
      checks++; if (m_data !== 8'h00) begin failures++; $display("FAIL rst_m_data got=%h exp=00", m_data); end
      checks++; if (m_last !== 1'b0) begin failures++; $display("FAIL rst_m_last got=%b exp=0", m_last); end
      checks++; if (frame_ok !== 1'b0 || frame_err !== 1'b0) begin failures++; $display("FAIL rst_pulses got=%b%b exp=00", frame_ok, frame_err); end
      checks++; if (err_code !== 3'd0) begin failures++; $display("FAIL rst_err_code got=%0d exp=0", err_code); end
      enable = 1'b0;
      idle(1);
      resetn = 1'b1;
      idle(2);
      enable = 1'b1;
      checks++; if (uart_rx_en !== 1'b0) begin failures++; $display("FAIL en_latency_pre got=%b exp=0", uart_rx_en); end
      idle(1);
      checks++; if (uart_rx_en !== 1'b1) begin failures++; $display("FAIL en_latency_post got=%b exp=1", uart_rx_en); end
   endtask

   task automatic test_good_frame();
      logic [7:0] exp_b[3] = '{8'h11, 8'h22, 8'h33};
      m_ready = 1'b1;
      send_byte(8'h7E); send_byte(8'h03);
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
      send_byte(8'h03);
      checks++; if (frame_ok !== 1'b1) begin failures++; $display("FAIL good_frame_ok got=%b exp=1", frame_ok); end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (m_valid !== 1'b1 || m_data !== exp_b[i] || m_last !== (i == 2)) begin
            failures++;
            $display("FAIL good_byte%0d got v=%b d=%h l=%b exp v=1 d=%h l=%b", i, m_valid, m_data, m_last, exp_b[i], (i == 2));
         end
         idle(1);
      end
      checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL good_valid_fall got=%b exp=0", m_valid); end
      checks++; if (mon_ok_novalid !== 0) begin failures++; $display("FAIL ok_without_valid got=%0d exp=0", mon_ok_novalid); end
   endtask

   task automatic test_csum_err();
      int v0 = mon_valid;
      send_byte(8'h7E); send_byte(8'h02); send_byte(8'hAA); send_byte(8'h55);
      send_byte(8'h00);
      checks++; if (frame_err !== 1'b1 || err_code !== 3'd2) begin failures++; $display("FAIL csum_err got=%b/%0d exp=1/2", frame_err, err_code); end
      idle(1);
      checks++; if (frame_err !== 1'b0 || err_code !== 3'd2) begin failures++; $display("FAIL csum_err_hold got=%b/%0d exp=0/2", frame_err, err_code); end
      idle(3);
      checks++; if (mon_valid !== v0) begin failures++; $display("FAIL csum_no_valid got=%0d exp=%0d", mon_valid, v0); end
   endtask

   task automatic test_len_bounds();
      logic [7:0] pl[$];
      bit done;
      send_byte(8'h7E); send_byte(8'h00);
      checks++; if (frame_err !== 1'b1 || err_code !== 3'd1) begin failures++; $display("FAIL len_zero got=%b/%0d exp=1/1", frame_err, err_code); end
      idle(1);
      send_byte(8'h7E); send_byte(8'(MAX_LEN + 1));
      checks++; if (frame_err !== 1'b1 || err_code !== 3'd1) begin failures++; $display("FAIL len_over got=%b/%0d exp=1/1", frame_err, err_code); end
      idle(1);
      for (int i = 0; i < MAX_LEN; i++) pl.push_back(8'($urandom));
      clear_mon();
      m_ready = 1'b1;
      send_frame(8'(MAX_LEN), pl, xor_sum(8'(MAX_LEN), pl));
      checks++; if (frame_ok !== 1'b1) begin failures++; $display("FAIL len_max_ok got=%b exp=1", frame_ok); end
      wait_drain(done);
      checks++; if (!done) begin failures++; $display("FAIL len_max_drain_timeout got=busy exp=idle"); end
      checks++; if (mon_data.size() !== MAX_LEN) begin failures++; $display("FAIL len_max_count got=%0d exp=%0d", mon_data.size(), MAX_LEN); end
      for (int i = 0; i < MAX_LEN && i < mon_data.size(); i++) begin
         checks++;
         if (mon_data[i] !== pl[i] || mon_last[i] !== (i == MAX_LEN - 1)) begin
            failures++;
            $display("FAIL len_max_byte%0d got=%h/%b exp=%h/%b", i, mon_data[i], mon_last[i], pl[i], (i == MAX_LEN - 1));
         end
      end
   endtask

   task automatic test_break();
      bit done;
      m_ready = 1'b1;
      send_byte(8'h7E); send_byte(8'h04); send_byte(8'h01);
      send_byte(8'h00, 1'b1);
      checks++; if (frame_err !== 1'b1 || err_code !== 3'd3) begin failures++; $display("FAIL brk_err got=%b/%0d exp=1/3", frame_err, err_code); end
      clear_mon();
      send_byte(8'h7E); send_byte(8'h01); send_byte(8'h5A); send_byte(8'h5B);
      checks++; if (frame_ok !== 1'b1) begin failures++; $display("FAIL brk_next_ok got=%b exp=1", frame_ok); end
      wait_drain(done);
      checks++; if (mon_data.size() !== 1 || mon_data[0] !== 8'h5A) begin failures++; $display("FAIL brk_next_data got=%0d bytes exp=1 byte 5a", mon_data.size()); end
   endtask

   task automatic test_backpressure_overrun();
      logic [7:0] pl[$];
      logic [7:0] held;
      int unstable = 0;
      bit done;
      for (int i = 0; i < 5; i++) pl.push_back(8'($urandom));
      m_ready = 1'b0;
      clear_mon();
      send_frame(8'd5, pl, xor_sum(8'd5, pl));
      held = m_data;
      checks++; if (m_valid !== 1'b1 || held !== pl[0]) begin failures++; $display("FAIL bp_first got=%b/%h exp=1/%h", m_valid, held, pl[0]); end
      for (int i = 0; i < 100; i++) begin
         if (i == 40) begin
            send_byte(8'($urandom));
            checks++;
            if (frame_err !== 1'b1 || err_code !== 3'd5 || m_valid !== 1'b1) begin
               failures++;
               $display("FAIL ovr_err got=%b/%0d v=%b exp=1/5 v=1", frame_err, err_code, m_valid);
            end
         end else begin
            idle(1);
         end
         if (m_valid !== 1'b1 || m_data !== held) unstable++;
      end
      checks++; if (unstable !== 0) begin failures++; $display("FAIL bp_stable got=%0d unstable cycles exp=0", unstable); end
      checks++; if (mon_err.size() !== 1) begin failures++; $display("FAIL ovr_single_pulse got=%0d exp=1", mon_err.size()); end
      m_ready = 1'b1;
      wait_drain(done);
      checks++; if (!done || mon_data.size() !== 5) begin failures++; $display("FAIL bp_count got=%0d exp=5", mon_data.size()); end
      for (int i = 0; i < 5 && i < mon_data.size(); i++) begin
         checks++;
         if (mon_data[i] !== pl[i] || mon_last[i] !== (i == 4)) begin
            failures++;
            $display("FAIL bp_byte%0d got=%h/%b exp=%h/%b", i, mon_data[i], mon_last[i], pl[i], (i == 4));
         end
      end
   endtask

   task automatic test_timeout();
      bit done;
      m_ready = 1'b1;
      clear_mon();
      send_byte(8'h7E); send_byte(8'h02);
`ifdef RX_FRAME_TIMEOUT_EN
      idle(TMO - 1);
      checks++; if (mon_err.size() !== 0) begin failures++; $display("FAIL tmo_early got=%0d errors exp=0", mon_err.size()); end
      idle(1);
      checks++; if (frame_err !== 1'b1 || err_code !== 3'd4) begin failures++; $display("FAIL tmo_err got=%b/%0d exp=1/4", frame_err, err_code); end
`else
      idle(TMO + 10);
      checks++; if (mon_err.size() !== 0) begin failures++; $display("FAIL tmo_disabled got=%0d errors exp=0", mon_err.size()); end
      send_byte(8'hAB); send_byte(8'hCD); send_byte(8'h02 ^ 8'hAB ^ 8'hCD);
      checks++; if (frame_ok !== 1'b1) begin failures++; $display("FAIL tmo_disabled_ok got=%b exp=1", frame_ok); end
      wait_drain(done);
`endif
      // a byte landing on the would-be expiry edge keeps the frame alive
      clear_mon();
      send_byte(8'h7E); send_byte(8'h01);
      idle(TMO - 1);
      send_byte(8'h99);
      send_byte(8'h98);
      checks++; if (frame_ok !== 1'b1 || mon_err.size() !== 0) begin failures++; $display("FAIL tmo_byte_wins got=%b/%0d exp=1/0", frame_ok, mon_err.size()); end
      wait_drain(done);
   endtask

   task automatic test_back_to_back();
      m_ready = 1'b1;
      send_byte(8'h7E); send_byte(8'h02); send_byte(8'h10); send_byte(8'h20);
      send_byte(8'h02 ^ 8'h10 ^ 8'h20);
      idle(1);
      checks++; if (m_last !== 1'b1 || m_data !== 8'h20) begin failures++; $display("FAIL b2b_last got=%b/%h exp=1/20", m_last, m_data); end
      idle(1);
      checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL b2b_idle got=%b exp=0", m_valid); end
      send_byte(8'h7E); send_byte(8'h01); send_byte(8'h3C); send_byte(8'h3D);
      checks++; if (frame_ok !== 1'b1 || m_data !== 8'h3C) begin failures++; $display("FAIL b2b_second got=%b/%h exp=1/3c", frame_ok, m_data); end
      idle(2);
   endtask

   task automatic test_enable_low();
      int ok0;
      m_ready = 1'b1;
      clear_mon();
      send_byte(8'h7E); send_byte(8'h03); send_byte(8'h01);
      enable = 1'b0; idle(1); enable = 1'b1; idle(1);
      checks++; if (mon_err.size() !== 0) begin failures++; $display("FAIL en_low_silent got=%0d errors exp=0", mon_err.size()); end
      ok0 = mon_ok;
      enable = 1'b0; send_byte(8'h7E); enable = 1'b1;
      send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
      idle(2);
      checks++; if (mon_ok !== ok0 || m_valid !== 1'b0) begin failures++; $display("FAIL en_low_sof_ignored got=%0d exp=%0d", mon_ok, ok0); end
      send_byte(8'h7E); send_byte(8'h02);
      enable = 1'b0;
      send_byte(8'h00, 1'b1);
      enable = 1'b1;
      checks++; if (frame_err !== 1'b1 || err_code !== 3'd3) begin failures++; $display("FAIL brk_with_en_fall got=%b/%0d exp=1/3", frame_err, err_code); end
      idle(1);
   endtask

   task automatic test_random();
      logic [7:0] exp_data[$];
      bit         exp_last[$];
      int         exp_err[$];
      int         ok0 = mon_ok;
      int         exp_ok = 0;
      bit         done;
      clear_mon();
      rand_ready = 1'b1;
      for (int f = 0; f < 25; f++) begin
         int kind = $urandom_range(0, 3);
         int len  = $urandom_range(1, MAX_LEN);
         logic [7:0] pl[$];
         logic [7:0] cs;
         for (int g = $urandom_range(0, 2); g > 0; g--) begin
            logic [7:0] junk = 8'($urandom_range(0, 255));
            if (junk == 8'h7E) junk = 8'h7F;
            send_byte(junk, 1'($urandom_range(0, 1)));
         end
         for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
         cs = xor_sum(8'(len), pl);
         case (kind)
            0: begin
               foreach (pl[i]) begin
                  exp_data.push_back(pl[i]);
                  exp_last.push_back(i == len - 1);
               end
               exp_ok++;
            end
            1: begin
               cs = cs ^ 8'($urandom_range(1, 255));
               exp_err.push_back(2);
            end
            2: exp_err.push_back(1);
            default: exp_err.push_back(3);
         endcase
         send_byte(8'h7E);
         idle($urandom_range(0, 3));
         if (kind == 2) begin
            send_byte(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAX_LEN + 1, 255)));
         end else if (kind == 3) begin
            int k = $urandom_range(0, len);
            send_byte(8'(len));
            for (int i = 0; i < k; i++) begin
               idle($urandom_range(0, 3));
               send_byte(pl[i]);
            end
            send_byte(8'h00, 1'b1);
         end else begin
            send_byte(8'(len));
            foreach (pl[i]) begin
               idle($urandom_range(0, 3));
               send_byte(pl[i]);
            end
            idle($urandom_range(0, 3));
            send_byte(cs);
         end
         wait_drain(done);
         checks++; if (!done) begin failures++; $display("FAIL rnd_drain_timeout frame=%0d got=busy exp=idle", f); end
         idle(1);
      end
      rand_ready = 1'b0;
      idle(1);
      m_ready = 1'b1;
      checks++; if (mon_ok - ok0 !== exp_ok) begin failures++; $display("FAIL rnd_ok_count got=%0d exp=%0d", mon_ok - ok0, exp_ok); end
      checks++; if (mon_data.size() !== exp_data.size()) begin failures++; $display("FAIL rnd_byte_count got=%0d exp=%0d", mon_data.size(), exp_data.size()); end
      for (int i = 0; i < exp_data.size() && i < mon_data.size(); i++) begin
         checks++;
         if (mon_data[i] !== exp_data[i] || mon_last[i] !== exp_last[i]) begin
            failures++;
            $display("FAIL rnd_byte%0d got=%h/%b exp=%h/%b", i, mon_data[i], mon_last[i], exp_data[i], exp_last[i]);
         end
      end
      checks++; if (mon_err.size() !== exp_err.size()) begin failures++; $display("FAIL rnd_err_count got=%0d exp=%0d", mon_err.size(), exp_err.size()); end
      for (int i = 0; i < exp_err.size() && i < mon_err.size(); i++) begin
         checks++;
         if (mon_err[i] !== exp_err[i]) begin failures++; $display("FAIL rnd_err%0d got=%0d exp=%0d", i, mon_err[i], exp_err[i]); end
      end
   endtask

   initial begin
      test_reset();
      test_good_frame();
      test_csum_err();
      test_len_bounds();
      test_break();
      test_backpressure_overrun();
      test_timeout();
      test_back_to_back();
      test_enable_low();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
